alu_ac: RTL and testbench

Accumulator/ALU stage sitting directly downstream of the processor control unit. It consumes the per-cycle `alu_mode`, AC write-enable, AC clear and AC increment controls, operates on the shared data bus value, and holds the accumulator (AC). It returns the `z` flag that the control unit tests for conditional jumps. Multiplication is iterative (shift-add), with a busy/done handshake, so matrix-multiply programs can stall on it.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_ac_mul.sv | 76 +++++++
 rtl/alu_ac.sv | 107 ++++++++++
 tb/tb_alu_ac.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU mode codes, FSM state encoding and default width
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_PASS = 4'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_ac_mul.sv
// rtl/alu_ac_mul.sv - iterative shift-add multiplier (shift_add_mul), one multiplier bit per cycle
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  alu_state_t       state;
  alu_state_t       state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] partial;
  logic [CW-1:0]    cnt;
  logic             last;

  // mcand is pre-shifted each cycle, so it already equals multiplicand<<i;
  // product is the partial sum after this cycle's bit, valid to capture on
  // the final iteration edge.
  assign last    = (cnt == CW'(WIDTH - 1));
  assign product = partial + (mplier[0] ? mcand : '0);
  assign busy    = (state == ST_MUL);
  assign done    = busy && last && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: leave MUL on abort or after the last bit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_MUL;
      ST_MUL:  if (abort || last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latching and one shift-add step per cycle while multiplying
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      cnt     <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        mcand   <= multiplicand;
        mplier  <= multiplier;
        partial <= '0;
        cnt     <= '0;
      end
    end else if (abort) begin
      cnt <= '0;
    end else begin
      partial <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_ac.sv
// rtl/alu_ac.sv - accumulator/ALU stage with flags and MUL handshake; ALU_FAST_MUL_EN selects single-cycle multiply
module alu_ac
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [3:0]       alu_mode,
  input  logic             ac_we,
  input  logic             clr_ac,
  input  logic             inc_ac,
  output logic [WIDTH-1:0] ac_out,
  output logic             z,
  output logic             c,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] ac_nxt;
  logic             c_nxt;
  logic             done_nxt;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // Top bit of the widened difference is set exactly when bus_in > AC.
  assign add_sum  = {1'b0, ac_out} + {1'b0, bus_in};
  assign sub_diff = {1'b0, ac_out} - {1'b0, bus_in};

`ifdef ALU_FAST_MUL_EN
  assign mul_product = ac_out * bus_in;
  assign mul_done    = 1'b0;
  assign busy        = 1'b0;
`else
  logic mul_start;

  // A MUL only starts when nothing of higher priority is asserted.
  assign mul_start = ac_we && !clr_ac && !inc_ac && !busy && (alu_mode == ALU_MUL);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .abort        (clr_ac),
    .multiplicand (ac_out),
    .multiplier   (bus_in),
    .busy         (busy),
    .done         (mul_done),
    .product      (mul_product)
  );
`endif

  // Next AC/flags: clear beats everything, busy blocks inc/write, then inc > write
  always_comb begin
    ac_nxt   = ac_out;
    c_nxt    = c;
    done_nxt = 1'b0;
    if (clr_ac) begin
      ac_nxt = '0;
      c_nxt  = 1'b0;
    end else if (busy) begin
      if (mul_done) begin
        ac_nxt   = mul_product;
        done_nxt = 1'b1;
      end
    end else if (inc_ac) begin
      ac_nxt = ac_out + 1'b1;
    end else if (ac_we) begin
      case (alu_mode)
        ALU_ADD:  {c_nxt, ac_nxt} = add_sum;
        ALU_SUB: begin
          ac_nxt = sub_diff[WIDTH-1:0];
          c_nxt  = sub_diff[WIDTH];
        end
        ALU_PASS: ac_nxt = bus_in;
        ALU_MUL: begin
`ifdef ALU_FAST_MUL_EN
          ac_nxt   = mul_product;
          done_nxt = 1'b1;
`else
          ac_nxt   = ac_out;
`endif
        end
        default:  ac_nxt = ac_out;
      endcase
    end
  end

  // Registered AC, flags and done pulse; z tracks the value being written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_out <= '0;
      z      <= 1'b1;
      c      <= 1'b0;
      done   <= 1'b0;
    end else begin
      ac_out <= ac_nxt;
      z      <= (ac_nxt == '0);
      c      <= c_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ac.sv
// tb/tb_alu_ac.sv - directed self-checking bench for alu_ac (iterative MUL build)
module tb_alu_ac;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus_in;
  logic [3:0]  alu_mode;
  logic        ac_we;
  logic        clr_ac;
  logic        inc_ac;
  logic [15:0] ac_out;
  logic        z;
  logic        c;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;

  alu_ac #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_in   (bus_in),
    .alu_mode (alu_mode),
    .ac_we    (ac_we),
    .clr_ac   (clr_ac),
    .inc_ac   (inc_ac),
    .ac_out   (ac_out),
    .z        (z),
    .c        (c),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] m, input logic [15:0] d);
    alu_mode = m;
    bus_in   = d;
    ac_we    = 1'b1;
    step();
    ac_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (ac_out !== 16'h0000) begin n_bad++; $display("FAIL reset_ac got %h want 0000", ac_out); end
    n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL reset_z got %b want 1", z); end
    n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL reset_c got %b want 0", c); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_sub();
    op(4'd5, 16'd3);
    op(4'd0, 16'd5);
    n_cmp++; if (ac_out !== 16'd8) begin n_bad++; $display("FAIL add_ac got %h want 0008", ac_out); end
    n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL add_z got %b want 0", z); end
    n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL add_c got %b want 0", c); end
    op(4'd1, 16'd8);
    n_cmp++; if (ac_out !== 16'd0) begin n_bad++; $display("FAIL sub_zero_ac got %h want 0000", ac_out); end
    n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL sub_zero_z got %b want 1", z); end
    n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL sub_zero_c got %b want 0", c); end
    op(4'd1, 16'd1);
    n_cmp++; if (ac_out !== 16'hFFFF) begin n_bad++; $display("FAIL sub_borrow_ac got %h want ffff", ac_out); end
    n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL sub_borrow_c got %b want 1", c); end
    n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL sub_borrow_z got %b want 0", z); end
  endtask

  task automatic test_add_overflow();
    op(4'd5, 16'hFFFF);
    op(4'd0, 16'd2);
    n_cmp++; if (ac_out !== 16'h0001) begin n_bad++; $display("FAIL ovf_ac got %h want 0001", ac_out); end
    n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL ovf_c got %b want 1", c); end
    inc_ac = 1'b1;
    step();
    inc_ac = 1'b0;
    n_cmp++; if (ac_out !== 16'h0002) begin n_bad++; $display("FAIL inc_ac got %h want 0002", ac_out); end
    n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL inc_c got %b want 1", c); end
    op(4'd3, 16'h1234);
    n_cmp++; if (ac_out !== 16'h0002) begin n_bad++; $display("FAIL nop_ac got %h want 0002", ac_out); end
  endtask

  task automatic test_mul();
    int busy_cnt;
    busy_cnt = 0;
    op(4'd5, 16'd7);
    op(4'd2, 16'd9);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mul_busy_start got %b want 1", busy); end
    for (int k = 1; k <= 16; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (k == 3) begin alu_mode = 4'd0; bus_in = 16'd100; ac_we = 1'b1; end
      if (k == 5) inc_ac = 1'b1;
      step();
      ac_we  = 1'b0;
      inc_ac = 1'b0;
      if (k < 16) begin
        n_cmp++; if (ac_out !== 16'd7 || done !== 1'b0) begin n_bad++; $display("FAIL mul_hold_%0d got ac=%h done=%b want ac=0007 done=0", k, ac_out, done); end
      end
    end
    n_cmp++; if (busy_cnt != 16) begin n_bad++; $display("FAIL mul_busy_cycles got %0d want 16", busy_cnt); end
    n_cmp++; if (ac_out !== 16'd63) begin n_bad++; $display("FAIL mul_ac got %h want 003f", ac_out); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mul_done got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mul_busy_end got %b want 0", busy); end
    n_cmp++; if (z !== 1'b0 || c !== 1'b1) begin n_bad++; $display("FAIL mul_flags got z=%b c=%b want z=0 c=1", z, c); end
    step();
    n_cmp++; if (done !== 1'b0 || ac_out !== 16'd63) begin n_bad++; $display("FAIL mul_after got done=%b ac=%h want done=0 ac=003f", done, ac_out); end
  endtask

  task automatic test_mul_trunc();
    int n;
    op(4'd5, 16'h0100);
    op(4'd2, 16'h0100);
    n = 1;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    n_cmp++; if (n != 17) begin n_bad++; $display("FAIL trunc_latency got %0d want 17", n); end
    n_cmp++; if (ac_out !== 16'h0000) begin n_bad++; $display("FAIL trunc_ac got %h want 0000", ac_out); end
    n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL trunc_z got %b want 1", z); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL trunc_done got %b want 1", done); end
  endtask

  task automatic test_abort_reset();
    int seen;
    op(4'd5, 16'd5);
    op(4'd2, 16'd5);
    for (int k = 0; k < 3; k++) step();
    clr_ac = 1'b1;
    step();
    clr_ac = 1'b0;
    n_cmp++; if (ac_out !== 16'd0 || z !== 1'b1 || c !== 1'b0) begin n_bad++; $display("FAIL abort_ac got ac=%h z=%b c=%b want 0000 1 0", ac_out, z, c); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin if (done === 1'b1) seen++; step(); end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end

    op(4'd5, 16'd5);
    op(4'd2, 16'd5);
    for (int k = 0; k < 9; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ac_out !== 16'd0 || z !== 1'b1 || c !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ac got ac=%h z=%b c=%b want 0000 1 0", ac_out, z, c); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got busy=%b done=%b want 0 0", busy, done); end
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin if (done === 1'b1) seen++; step(); end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_no_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int n;
    op(4'd5, 16'd3);
    op(4'd2, 16'd4);
    n = 1;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    n_cmp++; if (ac_out !== 16'd12 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_first got ac=%h done=%b want 000c 1", ac_out, done); end
    op(4'd2, 16'd5);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart got busy=%b want 1", busy); end
    n = 1;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    n_cmp++; if (n != 17) begin n_bad++; $display("FAIL b2b_latency got %0d want 17", n); end
    n_cmp++; if (ac_out !== 16'd60) begin n_bad++; $display("FAIL b2b_second got %h want 003c", ac_out); end

    op(4'd5, 16'd6);
    clr_ac   = 1'b1;
    alu_mode = 4'd2;
    bus_in   = 16'd3;
    ac_we    = 1'b1;
    step();
    clr_ac = 1'b0;
    ac_we  = 1'b0;
    n_cmp++; if (ac_out !== 16'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL clr_wins got ac=%h busy=%b want 0000 0", ac_out, busy); end
    step();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL clr_wins_late got busy=%b done=%b want 0 0", busy, done); end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    bus_in   = '0;
    alu_mode = '0;
    ac_we    = 1'b0;
    clr_ac   = 1'b0;
    inc_ac   = 1'b0;
    test_reset();
    test_add_sub();
    test_add_overflow();
    test_mul();
    test_mul_trunc();
    test_abort_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
